// File: rtl/mem_bist_ctrl.sv
// Memory BIST initiator: writes an address-derived pattern, reads it back and compares,
// then repeats with the inverted pattern; reports pass, first failing address and error count.
module mem_bist_ctrl #(
    parameter int          ADDRESS_WIDTH = 8,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] SEED          = 32'hA5A5_5A5A
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ADDRESS_WIDTH-1:0] fail_addr,
    output logic [ADDRESS_WIDTH+1:0] err_count,
    output logic                     mem_WR,
    output logic                     mem_RD,
    output logic [ADDRESS_WIDTH-1:0] mem_wraddr,
    output logic [ADDRESS_WIDTH-1:0] mem_rdaddr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);

    logic [2:0]               state;
    logic                     phase;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     pend_valid;
    logic [DATA_WIDTH-1:0]    pend_exp;
    logic [ADDRESS_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0]    pattern;
    logic                     mismatch;
    logic [ADDRESS_WIDTH+1:0] err_next;
    logic                     last_addr;

    always_comb begin
        pattern    = (DATA_WIDTH'(addr) ^ SEED_W) ^ {DATA_WIDTH{phase}};
        last_addr  = (addr == '1);
        mismatch   = pend_valid && (mem_dataOut != pend_exp);
        err_next   = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
        busy       = (state == WRITE) || (state == READ) || (state == DRAIN);
        done       = (state == DONE);
        mem_WR     = (state == WRITE);
        mem_RD     = (state == READ);
        mem_wraddr = mem_WR ? addr : '0;
        mem_rdaddr = mem_RD ? addr : '0;
        mem_dataIn = mem_WR ? pattern : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            addr       <= '0;
            pend_valid <= 1'b0;
            pend_exp   <= '0;
            pend_addr  <= '0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            err_count  <= '0;
        end else begin
            // Read data returns one cycle after mem_RD, so the expectation rides one stage behind.
            pend_valid <= (state == READ);
            pend_exp   <= pattern;
            pend_addr  <= addr;
            if (mismatch) begin
                err_count <= err_next;
                if (err_count == '0)
                    fail_addr <= pend_addr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WRITE;
                        phase     <= 1'b0;
                        addr      <= '0;
                        err_count <= '0;
                        fail_addr <= '0;
                        pass      <= 1'b0;
                    end
                end
                WRITE: begin
                    addr <= addr + 1'b1;
                    if (last_addr)
                        state <= READ;
                end
                READ: begin
                    addr <= addr + 1'b1;
                    if (last_addr)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!phase) begin
                        state <= WRITE;
                        phase <= 1'b1;
                        addr  <= '0;
                    end else begin
                        // The final compare lands this cycle, so pass uses the updated count.
                        state <= DONE;
                        pass  <= (err_next == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
